// File: rtl/memory_bus_arbiter.sv
// ---------------------------------------------------------------------------
// memory_bus_arbiter
//
// Shares the one processor memory bus between instruction fetch (read-only)
// and load/store (read/write). Only one transaction is in flight at a time.
// Load/store has fixed priority. A streak counter stops fetch from starving:
// once MAX_DATA_STREAK data grants have been made while fetch was waiting,
// the next arbitration goes to fetch.
//
// Handshake: a requester raises req and holds it, together with its
// address/data, until it sees its one-cycle gnt pulse. A read finishes with a
// one-cycle rsp_valid pulse, and rdata holds until the next read for that
// port. A write never produces a response. Once the arbiter has sampled a
// request in IDLE, the transaction runs to completion even if req drops
// before gnt.
//
// Ports:
//   clk, reset                      rising-edge clock, async active-high reset
//   fetch_req/fetch_addr            fetch read request
//   fetch_gnt/fetch_rsp_valid       fetch grant pulse / read-data-valid pulse
//   fetch_rdata                     fetch read data (held)
//   data_req/data_we/data_addr/
//   data_wdata                      load/store request
//   data_gnt/data_rsp_valid         load/store grant pulse / load-valid pulse
//   data_rdata                      load data (held)
//   rd_mem_en/rd_mem_addr           read strobe/address to the memory/IO mux
//   rd_mem_data                     read data from the mux, RD_LATENCY later
//   wr_mem_en/wr_mem_addr/
//   wr_mem_data                     write strobe/address/data to the mux
//   busy                            high whenever the FSM is not IDLE
//   dbg_state_o                     current FSM state (IDLE=0 ISSUE=1
//                                   WAIT=2 RESP=3)
// ---------------------------------------------------------------------------
module memory_bus_arbiter #(
    parameter int ADDR_BITS       = 16,
    parameter int DATA_BITS       = 8,
    parameter int RD_LATENCY      = 1,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fetch_req,
    input  logic [ADDR_BITS-1:0] fetch_addr,
    output logic                 fetch_gnt,
    output logic                 fetch_rsp_valid,
    output logic [DATA_BITS-1:0] fetch_rdata,
    input  logic                 data_req,
    input  logic                 data_we,
    input  logic [ADDR_BITS-1:0] data_addr,
    input  logic [DATA_BITS-1:0] data_wdata,
    output logic                 data_gnt,
    output logic                 data_rsp_valid,
    output logic [DATA_BITS-1:0] data_rdata,
    output logic                 rd_mem_en,
    output logic [ADDR_BITS-1:0] rd_mem_addr,
    input  logic [DATA_BITS-1:0] rd_mem_data,
    output logic                 wr_mem_en,
    output logic [ADDR_BITS-1:0] wr_mem_addr,
    output logic [DATA_BITS-1:0] wr_mem_data,
    output logic                 busy,
    output logic [1:0]           dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);
    // RD_LATENCY is 1..4, so the WAIT countdown fits in two bits.
    localparam logic [1:0] WAIT_LOAD = 2'(RD_LATENCY - 1);

    state_t               state_q;
    logic [1:0]           wait_q;
    logic [SW-1:0]        streak_q;
    logic [SW-1:0]        streak_d;
    logic                 win_fetch_q;   // winner of the in-flight transaction
    logic                 we_q;          // in-flight transaction is a write
    logic                 fetch_gnt_q;
    logic                 data_gnt_q;
    logic                 fetch_rsp_q;
    logic                 data_rsp_q;
    logic [DATA_BITS-1:0] fetch_rdata_q;
    logic [DATA_BITS-1:0] data_rdata_q;
    logic                 rd_en_q;
    logic [ADDR_BITS-1:0] rd_addr_q;
    logic                 wr_en_q;
    logic [ADDR_BITS-1:0] wr_addr_q;
    logic [DATA_BITS-1:0] wr_data_q;

    logic any_req;
    logic fetch_wins;

    assign any_req    = fetch_req | data_req;
    // Fetch takes the bus when load/store is quiet or the streak is used up.
    assign fetch_wins = fetch_req & (~data_req | (streak_q == STREAK_MAX));

    // The streak only moves in IDLE, where arbitration happens.
    always_comb begin
        streak_d = streak_q;
        if (state_q == IDLE) begin
            if (!fetch_req) begin
                streak_d = '0;
            end else if (fetch_wins) begin
                streak_d = '0;
            end else if (streak_q != STREAK_MAX) begin
                // data_req won while fetch waited
                streak_d = streak_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            wait_q        <= '0;
            streak_q      <= '0;
            win_fetch_q   <= 1'b0;
            we_q          <= 1'b0;
            fetch_gnt_q   <= 1'b0;
            data_gnt_q    <= 1'b0;
            fetch_rsp_q   <= 1'b0;
            data_rsp_q    <= 1'b0;
            fetch_rdata_q <= '0;
            data_rdata_q  <= '0;
            rd_en_q       <= 1'b0;
            rd_addr_q     <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
        end else begin
            // Pulses default low; each is raised for exactly one state.
            fetch_gnt_q <= 1'b0;
            data_gnt_q  <= 1'b0;
            fetch_rsp_q <= 1'b0;
            data_rsp_q  <= 1'b0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            streak_q    <= streak_d;

            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        win_fetch_q <= fetch_wins;
                        we_q        <= ~fetch_wins & data_we;
                        fetch_gnt_q <= fetch_wins;
                        data_gnt_q  <= ~fetch_wins;
                        // Strobes and addresses are registered here so they
                        // appear together with gnt in ISSUE.
                        if (fetch_wins) begin
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= fetch_addr;
                        end else if (!data_we) begin
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= data_addr;
                        end else begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= data_addr;
                            wr_data_q <= data_wdata;
                        end
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (we_q) begin
                        state_q <= IDLE;
                    end else begin
                        wait_q  <= WAIT_LOAD;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_q == 2'd0) begin
                        if (win_fetch_q) begin
                            fetch_rdata_q <= rd_mem_data;
                            fetch_rsp_q   <= 1'b1;
                        end else begin
                            data_rdata_q  <= rd_mem_data;
                            data_rsp_q    <= 1'b1;
                        end
                        state_q <= RESP;
                    end else begin
                        wait_q <= wait_q - 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign fetch_gnt       = fetch_gnt_q;
    assign data_gnt        = data_gnt_q;
    assign fetch_rsp_valid = fetch_rsp_q;
    assign data_rsp_valid  = data_rsp_q;
    assign fetch_rdata     = fetch_rdata_q;
    assign data_rdata      = data_rdata_q;
    assign rd_mem_en       = rd_en_q;
    assign rd_mem_addr     = rd_addr_q;
    assign wr_mem_en       = wr_en_q;
    assign wr_mem_addr     = wr_addr_q;
    assign wr_mem_data     = wr_data_q;
    assign busy            = (state_q != IDLE);
    assign dbg_state_o     = state_q;

endmodule

// File: doc/memory_bus_arbiter.md
Name: memory_bus_arbiter

Overview:
Shares the single processor memory bus between two requesters: instruction fetch (read-only) and load/store (read/write).
- Drives the rd_mem_*/wr_mem_* inputs of the memory/IO decode stage and returns read data to the winning requester.
- Fixed priority to load/store, with a starvation guard for fetch.
- One transaction in flight at a time. Output-port decoding stays in the downstream mux.

Parameters:
ADDR_BITS, 16, memory address width (matches constants_pkg::MEMORY_ADDRESS_BITS).
DATA_BITS, 8, memory data width (matches constants_pkg::MEMORY_DATA_BITS).
RD_LATENCY, 1, cycles from rd_mem_en to valid rd_mem_data; legal range 1..4.
MAX_DATA_STREAK, 4, consecutive data grants allowed while fetch waits; legal range >= 1.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
fetch_req  in  1  fetch read request; held high until fetch_gnt
fetch_addr  in  ADDR_BITS  fetch address
fetch_gnt  out  1  one-cycle pulse, fetch transaction issued
fetch_rsp_valid  out  1  one-cycle pulse, fetch_rdata valid
fetch_rdata  out  DATA_BITS  fetch read data
data_req  in  1  load/store request; held high until data_gnt
data_we  in  1  1 = write, 0 = read
data_addr  in  ADDR_BITS  load/store address
data_wdata  in  DATA_BITS  store data
data_gnt  out  1  one-cycle pulse, data transaction issued
data_rsp_valid  out  1  one-cycle pulse on read completion; never asserted for writes
data_rdata  out  DATA_BITS  load data
rd_mem_en  out  1  read strobe to the memory/IO mux
rd_mem_addr  out  ADDR_BITS  read address
rd_mem_data  in  DATA_BITS  read data from the mux
wr_mem_en  out  1  write strobe
wr_mem_addr  out  ADDR_BITS  write address
wr_mem_data  out  DATA_BITS  write data
busy  out  1  high whenever state != IDLE

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-high.
- On reset, every register and output is 0 and the FSM is in IDLE.
  - Reset mid-transaction aborts it; no gnt or rsp pulse is produced for it.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if any req is high, arbitrate, latch winner id, we, addr and wdata, then go to ISSUE. Otherwise stay.
  - ISSUE (1 cycle): the winner's gnt is 1.
    - Read: rd_mem_en=1, then go to WAIT with wait counter = RD_LATENCY-1.
    - Write: wr_mem_en=1 with the latched wr_mem_addr and wr_mem_data, then go to IDLE.
  - WAIT: rd_mem_addr is held stable. Decrement the counter each cycle.
    - In the cycle the counter is 0, register rd_mem_data into the winner's rdata and go to RESP.
  - RESP (1 cycle): the winner's rsp_valid is 1, then go to IDLE.
- Timing (request first seen high in IDLE at cycle T):
  - gnt and strobe at T+1.
  - Write: next request is sampled at T+2.
  - Read: rsp_valid at T+2+RD_LATENCY; next request is sampled at T+3+RD_LATENCY.
- Strobe rules:
  - rd_mem_en and wr_mem_en are never high together and are only high in ISSUE.
  - Address and data outputs hold their last latched values at all other times (0 after reset).
- Arbitration (evaluated in IDLE only):
  - data_req wins over fetch_req, unless fetch_req=1 and streak==MAX_DATA_STREAK; then fetch wins.
- Streak counter:
  - Increments on a data grant made while fetch_req=1.
  - Clears on a fetch grant, or on any IDLE cycle with fetch_req=0.
  - Saturates at MAX_DATA_STREAK.
- Holding data:
  - fetch_rdata and data_rdata hold their value until the next capture for that port.
  - rsp_valid lasts exactly one cycle.
- Protocol violation: a requester deasserting req between IDLE sampling and gnt does not cancel the latched transaction; it still completes.
- No address decoding: IO addresses 0xfffc..0xffff pass through unchanged.

Test Plan:
- Fetch read alone: RD_LATENCY=1, fetch_addr=0x0010, memory returns 0xA5 → fetch_gnt at T+1, rd_mem_en one cycle with addr 0x0010, fetch_rsp_valid at T+3 with fetch_rdata=0xA5, busy high T+1..T+3.
- Store: data_we=1, addr 0xfffd, wdata 0x3C → data_gnt and wr_mem_en at T+1 with addr 0xfffd and data 0x3C; no data_rsp_valid; new request accepted at T+2.
- Simultaneous requests: fetch read 0x0100 and data read 0x0200 in the same cycle → data served first, fetch gnt follows after the data RESP; responses routed to the correct ports.
- Starvation guard: MAX_DATA_STREAK=4, data_req and fetch_req held high continuously → grant order D,D,D,D,F,D,D,D,D,F.
- Latency parameter: RD_LATENCY=3, data read with memory data 0x77 valid 3 cycles after rd_mem_en → data_rsp_valid at T+5, data_rdata=0x77, rd_mem_addr stable through WAIT.
- Reset during WAIT: reset asserted asynchronously mid-cycle → all outputs 0 immediately, no rsp_valid; after release, a fresh fetch read completes normally.
